// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer time-sharing one full-adder cell, LSB first.
// Latency: start taken at edge E0, done pulses in the cycle after E(WIDTH); one op per WIDTH+2 cycles.
// Backpressure: start is only taken while ready (IDLE); in RUN/DONE it is ignored, not queued.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic w_accept;
    logic w_last;
    logic w_s;
    logic w_co;
    logic w_c_msb_in;

    // The single shared full-adder cell, fed from the bottom of the operand shifters.
    assign w_s        = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_co       = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    // On the last bit the carry flop holds the carry into the MSB.
    assign w_c_msb_in = r_carry;
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs decoded from the registered state.
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture, one bit of add per RUN cycle, and result/flag capture on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            // Subtract is a + ~b + 1: invert B and force the initial carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_co;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= w_c_msb_in ^ w_co;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 instance under random/directed/back-to-back
// traffic with a decoupled monitor, plus a WIDTH=2 instance checked exhaustively.
module tb_serial_add_ctrl;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          dcyc;
    } exp_t;

    int checks   = 0;
    int failures = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start, sub, cin;
    logic [7:0] a, b;
    logic       ready, done, cout, ovf;
    logic [7:0] sum;

    // WIDTH=2 instance
    logic       start2, sub2, cin2;
    logic [1:0] a2, b2;
    logic       ready2, done2, cout2, ovf2;
    logic [1:0] sum2;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .ready(ready), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_add_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .cin(cin2),
        .a(a2), .b(b2), .ready(ready2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: unsigned sum/carry and signed overflow from plain integer arithmetic.
    function automatic exp_t ref_op(input int w, input longint av, input longint bv,
                                    input logic ci, input logic sb, input int dcyc);
        exp_t   e;
        longint mask, half, full, sa, sbv, r;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        if (sb) full = av + ((~bv) & mask) + 1;
        else    full = av + bv + longint'(ci);
        e.sum  = 64'(full & mask);
        e.cout = ((full >> w) & 1) != 0;
        sa  = (av >= half) ? av - 2 * half : av;
        sbv = (bv >= half) ? bv - 2 * half : bv;
        r   = sb ? (sa - sbv) : (sa + sbv + longint'(ci));
        e.ovf  = (r < -half) || (r > half - 1);
        e.dcyc = dcyc;
        return e;
    endfunction

    exp_t q[$];
    int   cyc     = 0;
    int   next_ok = 0;
    logic mon_en  = 1'b0;

    // Stimulus-side model: decides which start samples are taken and when done is due.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            q.delete();
            next_ok = 0;
        end else if (start && cyc >= next_ok) begin
            q.push_back(ref_op(8, longint'(a), longint'(b), cin, sub, cyc + 8));
            next_ok = cyc + 10;
        end
    end

    logic mon_exp_done;
    exp_t mon_e;

    // Monitor: compares ready/done every cycle and pops the scoreboard on each done.
    always @(posedge clk) begin
        #1;
        if (rst_n && mon_en) begin
            chk("ready8", longint'(ready), longint'(cyc >= next_ok - 1));
            mon_exp_done = (q.size() > 0) && (q[0].dcyc == cyc);
            chk("done8", longint'(done), longint'(mon_exp_done));
            if (mon_exp_done) begin
                mon_e = q.pop_front();
                chk("sum8",  longint'(sum),  longint'(mon_e.sum));
                chk("cout8", longint'(cout), longint'(mon_e.cout));
                chk("ovf8",  longint'(ovf),  longint'(mon_e.ovf));
            end
        end
    end

    // One WIDTH=8 request, then wait until the block is back in IDLE.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic ci, input logic sb);
        @(negedge clk);
        a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
        repeat (9) @(negedge clk);
    endtask

    // One WIDTH=2 request with cycle-exact checks of done and results.
    task automatic op2(input logic [1:0] av, input logic [1:0] bv, input logic ci, input logic sb);
        exp_t e;
        e = ref_op(2, longint'(av), longint'(bv), ci, sb, 0);
        @(negedge clk);
        chk("w2_ready_idle", longint'(ready2), 1);
        a2 = av; b2 = bv; cin2 = ci; sub2 = sb; start2 = 1'b1;
        @(posedge clk); #1;
        chk("w2_ready_run", longint'(ready2), 0);
        @(negedge clk);
        start2 = 1'b0;
        @(posedge clk); #1;
        chk("w2_done_e1", longint'(done2), 0);
        @(posedge clk); #1;
        chk("w2_done_e2", longint'(done2), 1);
        chk("w2_sum",  longint'(sum2),  longint'(e.sum));
        chk("w2_cout", longint'(cout2), longint'(e.cout));
        chk("w2_ovf",  longint'(ovf2),  longint'(e.ovf));
        @(posedge clk); #1;
        chk("w2_done_e3", longint'(done2), 0);
    endtask

    initial begin
        start = 0; sub = 0; cin = 0; a = 0; b = 0;
        start2 = 0; sub2 = 0; cin2 = 0; a2 = 0; b2 = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", longint'(ready), 1);
        chk("rst_done",  longint'(done),  0);
        chk("rst_sum",   longint'(sum),   0);
        chk("rst_cout",  longint'(cout),  0);
        chk("rst_ovf",   longint'(ovf),   0);
        chk("rst_ready2", longint'(ready2), 1);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Directed corner cases, including subtract with cin=1 (cin must be ignored).
        op8(8'h5A, 8'h3C, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        op8(8'h00, 8'h00, 1'b1, 1'b0);
        op8(8'h10, 8'h20, 1'b0, 1'b1);
        op8(8'h80, 8'h01, 1'b0, 1'b1);
        op8(8'h10, 8'h20, 1'b1, 1'b1);
        op8(8'h7F, 8'h7F, 1'b1, 1'b0);

        // Random single requests.
        repeat (20) op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

        // start held high with operands changing every cycle.
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (12) @(negedge clk);

        // Abort after three bits have been processed.
        a = 8'hC3; b = 8'h7E; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", longint'(ready), 1);
        chk("abort_done",  longint'(done),  0);
        chk("abort_sum",   longint'(sum),   0);
        chk("abort_cout",  longint'(cout),  0);
        chk("abort_ovf",   longint'(ovf),   0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op8(8'h7F, 8'h01, 1'b0, 1'b0);
        op8(8'h00, 8'h00, 1'b0, 1'b0);

        // Every expected done must have been seen.
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain8", longint'(q.size()), 0);

        // WIDTH=2: directed case then every operand/mode combination.
        op2(2'b01, 2'b01, 1'b0, 1'b0);
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                for (int si = 0; si < 2; si++) begin
                    op2(2'(ai), 2'(bi), 1'($urandom), 1'(si));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
